cla_add_scheduler: RTL and testbench

Multi-cycle adder controller that shares one 6-bit carry-lookahead slice between two requesters. Each accepted request adds two (6·NUM_SLICES)-bit operands by sequencing the slice least-significant first, holding the carry in a register between slices. Sits between operand producers and the 6-bit CLA datapath. Arbitrates round-robin, with a valid/ready handshake on each request port and on the response port.

---
 rtl/cla_add_scheduler_pkg.sv | 15 +
 rtl/cla_add_scheduler_cla6_slice.sv | 44 ++++
 rtl/cla_add_scheduler.sv | 157 +++++++++++++++
 tb/tb_cla_add_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_add_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed carry-lookahead adder.
// Imported by cla6_slice and cla_add_scheduler.
package cla_sched_pkg;

    localparam int SLICE_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/cla_add_scheduler_cla6_slice.sv
// Combinational 6-bit carry-lookahead slice.
// Every carry is expanded from generate/propagate terms, so there is no ripple chain.
module cla6_slice
    import cla_sched_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c5
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Lookahead carries: c(i+1) = g(i) | p(i)g(i-1) | ... | p(i..0)cin
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];
    assign c5   = c[SLICE_W-1];

endmodule

// File: rtl/cla_add_scheduler.sv
// Two-port round-robin scheduler sharing one 6-bit CLA slice, LSB slice first.
// Define CLA_SCHED_OVF_EN to add the registered signed-overflow output rsp_ovf.
module cla_add_scheduler
    import cla_sched_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] req0_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] req0_b,
    input  logic                          req0_cin,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] req1_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] req1_b,
    input  logic                          req1_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] rsp_sum,
    output logic                          rsp_cout,
    output logic                          rsp_id,
`ifdef CLA_SCHED_OVF_EN
    output logic                          rsp_ovf,
`endif
    output logic                          busy
);

    localparam int W  = SLICE_W * NUM_SLICES;
    localparam int KW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_SLICES - 1);

    state_t        state;
    logic [KW-1:0] k;
    logic          carry_reg;
    req_id_t       last_grant;
    req_id_t       id_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    logic               grant0;
    logic               grant1;
    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout;

    // Round-robin winner: the sole requester, or on a tie the one not served last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant == 1'b1);
            grant1 = req1_valid && (!req0_valid || last_grant == 1'b0);
        end
    end

    assign req0_ready = !rst && grant0;
    assign req1_ready = !rst && grant1;
    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    assign sl_a = a_q[int'(k)*SLICE_W +: SLICE_W];
    assign sl_b = b_q[int'(k)*SLICE_W +: SLICE_W];

`ifdef CLA_SCHED_OVF_EN
    logic sl_c5;

    cla6_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_reg),
        .sum  (sl_sum),
        .cout (sl_cout),
        .c5   (sl_c5)
    );

    // Overflow is captured together with the final carry out
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if (state == RUN && k == K_LAST) begin
            rsp_ovf <= sl_c5 ^ sl_cout;
        end
    end
`else
    cla6_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_reg),
        .sum  (sl_sum),
        .cout (sl_cout),
        .c5   ()
    );
`endif

    // Control FSM, operand capture and per-slice result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            carry_reg  <= 1'b0;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant0) begin
                        a_q        <= req0_a;
                        b_q        <= req0_b;
                        carry_reg  <= req0_cin;
                        id_q       <= 1'b0;
                        last_grant <= 1'b0;
                        k          <= '0;
                        state      <= RUN;
                    end else if (grant1) begin
                        a_q        <= req1_a;
                        b_q        <= req1_b;
                        carry_reg  <= req1_cin;
                        id_q       <= 1'b1;
                        last_grant <= 1'b1;
                        k          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    rsp_sum[int'(k)*SLICE_W +: SLICE_W] <= sl_sum;
                    carry_reg <= sl_cout;
                    if (k == K_LAST) begin
                        k        <= '0;
                        rsp_cout <= sl_cout;
                        rsp_id   <= id_q;
                        state    <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_add_scheduler.sv
// Scoreboard bench for cla_add_scheduler with NUM_SLICES = 4 (24-bit operands).
// Expected results are modelled at accept time and compared when a response is taken.
module tb_cla_add_scheduler;

    localparam int NS = 4;
    localparam int W  = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_cin = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_cin = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_id;
    logic         rsp_ovf;
    logic         busy;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt0    = 0;
    int   cnt1    = 0;

    cla_add_scheduler #(.NUM_SLICES(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
`ifdef CLA_SCHED_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .busy       (busy)
    );

`ifndef CLA_SCHED_OVF_EN
    assign rsp_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic id);
        exp_t e;
        logic [W:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.id   = id;
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                q.push_back(model(req0_a, req0_b, req0_cin, 1'b0));
                cnt0++;
            end
            if (req1_valid && req1_ready) begin
                q.push_back(model(req1_a, req1_b, req1_cin, 1'b1));
                cnt1++;
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'(q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_sum", 32'(rsp_sum), 32'(e.sum));
                    check("sb_cout", 32'(rsp_cout), 32'(e.cout));
                    check("sb_id", 32'(rsp_id), 32'(e.id));
`ifdef CLA_SCHED_OVF_EN
                    check("sb_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_req(input logic p, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c);
        @(posedge clk);
        #1;
        if (!p) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = c;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = c;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((!p && req0_ready) || (p && req1_ready)) begin
                @(posedge clk);
                #1;
                // operands scrambled after accept must not affect the result
                if (!p) begin
                    req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
                end else begin
                    req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
                end
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                return;
            end
        end
        check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) return;
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state, with valids high to show readies are forced low
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_r0", 32'(req0_ready), 32'd0);
        check("rst_r1", 32'(req1_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        check("rst_cout", 32'(rsp_cout), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_ovf", 32'(rsp_ovf), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single op, latency of NS+1 edges
        rsp_ready = 1'b1;
        do_req(1'b0, 24'h000FFF, 24'h000001, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_rsp(n);
        check("t1_latency", 32'(n), 32'd5);
        check("t1_sum", 32'(rsp_sum), 32'h001000);
        check("t1_cout", 32'(rsp_cout), 32'd0);
        check("t1_id", 32'(rsp_id), 32'd0);

        // Carry ripples through every slice
        do_req(1'b1, 24'hFFFFFF, 24'h000000, 1'b1);
        wait_rsp(n);
        check("t2_sum", 32'(rsp_sum), 32'h000000);
        check("t2_cout", 32'(rsp_cout), 32'd1);
        check("t2_id", 32'(rsp_id), 32'd1);
        wait_idle();

        // Tie from reset: req0 first, then req1, then req0 again
        do_reset();
        cnt0 = 0;
        cnt1 = 0;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 24'h000010; req0_b = 24'h000020; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 24'h100000; req1_b = 24'h000005; req1_cin = 1'b1;
        @(negedge clk);
        check("tie1_r0", 32'(req0_ready), 32'd1);
        check("tie1_r1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (req1_ready) got = 1'b1;
            end
            if (!got) check("tie1_req1_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_idle();
        check("tie1_cnt0", 32'(cnt0), 32'd1);
        check("tie1_cnt1", 32'(cnt1), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 24'h0ABCDE; req0_b = 24'h012345;
        req1_valid = 1'b1; req1_a = 24'h333333; req1_b = 24'h444444;
        @(negedge clk);
        check("tie2_r0", 32'(req0_ready), 32'd1);
        check("tie2_r1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Back-pressure: DONE held three cycles
        rsp_ready = 1'b0;
        do_req(1'b0, 24'h00003F, 24'h000001, 1'b0);
        wait_rsp(n);
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_sum", 32'(rsp_sum), 32'h000040);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_r0", 32'(req0_ready), 32'd0);
            check("bp_r1", 32'(req1_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        check("bp_rel_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_after_valid", 32'(rsp_valid), 32'd0);
        check("bp_after_sum", 32'(rsp_sum), 32'h000040);
        check("bp_after_busy", 32'(busy), 32'd0);

        // Reset while k = 2 discards the operation
        do_req(1'b0, 24'hABCDEF, 24'h111111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 24'h123456; req0_b = 24'h111111; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 24'h000001; req1_b = 24'h000001;
        @(negedge clk);
        check("mid_rst_grant0", 32'(req0_ready), 32'd1);
        check("mid_rst_grant1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(n);
        check("mid_rst_sum", 32'(rsp_sum), 32'h234567);
        wait_idle();

`ifdef CLA_SCHED_OVF_EN
        do_req(1'b0, 24'h7FFFFF, 24'h000001, 1'b0);
        wait_rsp(n);
        check("ovf1_ovf", 32'(rsp_ovf), 32'd1);
        check("ovf1_cout", 32'(rsp_cout), 32'd0);
        do_req(1'b1, 24'h800000, 24'hFFFFFF, 1'b0);
        wait_rsp(n);
        check("ovf2_ovf", 32'(rsp_ovf), 32'd1);
        check("ovf2_cout", 32'(rsp_cout), 32'd1);
        do_req(1'b0, 24'h000001, 24'hFFFFFF, 1'b0);
        wait_rsp(n);
        check("ovf3_ovf", 32'(rsp_ovf), 32'd0);
        check("ovf3_cout", 32'(rsp_cout), 32'd1);
        wait_idle();
`endif

        // Random operations through the scoreboard
        for (int i = 0; i < 10; i++) begin
            do_req(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                   1'($urandom_range(0, 1)));
            wait_rsp(n);
        end
        wait_idle();
        check("sb_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
